// File: rtl/k052109_vram_slot_arbiter.sv
// k052109_vram_slot_arbiter: time-division arbiter for the tilemap VRAM.
// A free-running 4-phase sequencer generates the PE/PQ strobes and gives the
// single synchronous VRAM port to the video fetch in ph0 and to the CPU in ph2.
// Optional feature macro: K052109_CPU_WAIT_EN (drives cpu_wait while a CPU
// access is pending; tied low when undefined).
module k052109_vram_slot_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vid_en,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic          vram_en,
  output logic          vram_we,
  output logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_wdata,
  input  logic [DW-1:0] vram_rdata,
  output logic          pe,
  output logic          pq
);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t        r_ph;
  phase_t        w_ph_next;
  logic          w_end_ph1;
  logic          w_end_ph3;
  logic          w_pq_next;
  logic          w_pe_next;
  logic          w_cpu_accept;

  logic          r_pq;
  logic          r_pe;
  logic          r_vram_en;
  logic          r_vram_we;
  logic [AW-1:0] r_vram_addr;
  logic [DW-1:0] r_vram_wdata;
  logic          r_vid_rd;
  logic [DW-1:0] r_vid_data;
  logic          r_vid_valid;
  logic          r_cpu_pend;
  logic          r_cpu_issued;
  logic          r_cpu_blocked;
  logic          r_cpu_we;
  logic [AW-1:0] r_cpu_addr;
  logic [DW-1:0] r_cpu_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_cpu_ack;

  // Phase state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ph <= PH0;
    else       r_ph <= w_ph_next;
  end

  // Next phase: free-running, wraps ph3 -> ph0
  always_comb begin
    w_ph_next = PH0;
    case (r_ph)
      PH0:     w_ph_next = PH1;
      PH1:     w_ph_next = PH2;
      PH2:     w_ph_next = PH3;
      default: w_ph_next = PH0;
    endcase
  end

  // Phase decode: edge markers and next-cycle strobe levels
  always_comb begin
    w_end_ph1 = (r_ph == PH1);
    w_end_ph3 = (r_ph == PH3);
    w_pq_next = (w_ph_next == PH1) || (w_ph_next == PH2);
    w_pe_next = (w_ph_next == PH2) || (w_ph_next == PH3);
  end

  // A held request is ignored until it has been seen low once after an accept
  assign w_cpu_accept = cpu_req && !r_cpu_pend && !r_cpu_ack && !r_cpu_blocked;

  // Registered quadrature strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pq <= 1'b0;
      r_pe <= 1'b0;
    end else begin
      r_pq <= w_pq_next;
      r_pe <= w_pe_next;
    end
  end

  // VRAM port: video slot lands in ph0, CPU slot in ph2, idle otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vram_en    <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
    end else begin
      r_vram_en <= 1'b0;
      r_vram_we <= 1'b0;
      if (w_end_ph3 && vid_en) begin
        r_vram_en   <= 1'b1;
        r_vram_addr <= vid_addr;
      end else if (w_end_ph1 && r_cpu_pend) begin
        r_vram_en    <= 1'b1;
        r_vram_we    <= r_cpu_we;
        r_vram_addr  <= r_cpu_addr;
        r_vram_wdata <= r_cpu_wdata;
      end
    end
  end

  // Video read capture: data from the ph0 read arrives for the ph1->ph2 edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vid_rd    <= 1'b0;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_vid_valid <= 1'b0;
      if (w_end_ph3) r_vid_rd <= vid_en;
      if (w_end_ph1 && r_vid_rd) begin
        r_vid_data  <= vram_rdata;
        r_vid_valid <= 1'b1;
      end
    end
  end

  // CPU accept, slot issue and completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cpu_pend    <= 1'b0;
      r_cpu_issued  <= 1'b0;
      r_cpu_blocked <= 1'b0;
      r_cpu_we      <= 1'b0;
      r_cpu_addr    <= '0;
      r_cpu_wdata   <= '0;
      r_cpu_rdata   <= '0;
      r_cpu_ack     <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      if (w_end_ph1 && r_cpu_pend) r_cpu_issued <= 1'b1;
      // Only an access that actually used this frame's ph2 slot completes here
      if (w_end_ph3 && r_cpu_issued) begin
        r_cpu_issued <= 1'b0;
        r_cpu_pend   <= 1'b0;
        r_cpu_ack    <= 1'b1;
        if (!r_cpu_we) r_cpu_rdata <= vram_rdata;
      end
      if (w_cpu_accept) begin
        r_cpu_pend    <= 1'b1;
        r_cpu_blocked <= 1'b1;
        r_cpu_we      <= cpu_we;
        r_cpu_addr    <= cpu_addr;
        r_cpu_wdata   <= cpu_wdata;
      end else if (!cpu_req) begin
        r_cpu_blocked <= 1'b0;
      end
    end
  end

`ifdef K052109_CPU_WAIT_EN
  // Pending spans exactly the cycle after accept through the cycle before ack
  assign cpu_wait = r_cpu_pend;
`else
  assign cpu_wait = 1'b0;
`endif

  assign pq         = r_pq;
  assign pe         = r_pe;
  assign vram_en    = r_vram_en;
  assign vram_we    = r_vram_we;
  assign vram_addr  = r_vram_addr;
  assign vram_wdata = r_vram_wdata;
  assign vid_data   = r_vid_data;
  assign vid_valid  = r_vid_valid;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ack    = r_cpu_ack;

endmodule

// File: tb/tb_k052109_vram_slot_arbiter.sv
// Testbench for k052109_vram_slot_arbiter: directed steps plus randomized
// CPU transactions and video traffic, checked against a cycle-schedule model.
module tb_k052109_vram_slot_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
`ifdef K052109_CPU_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vid_en = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;
  logic          vram_en;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic [DW-1:0] vram_rdata;
  logic          pe;
  logic          pq;

  k052109_vram_slot_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .vid_en(vid_en), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .pe(pe), .pq(pq)
  );

  always #5 clock = ~clock;

  // Counters and scoreboard state
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int tb_cyc;
  int accept_at = -1;
  int issue_at = -1;
  int ack_at = -1;
  bit txn_we;
  logic [AW-1:0] txn_addr;
  logic [DW-1:0] txn_wdata;
  logic [DW-1:0] txn_rdata;
  bit frame_vid = 1'b0;
  logic [AW-1:0] frame_vaddr = '0;
  bit rand_vid = 1'b0;

  // VRAM model: initial image from a pattern, overridden by observed writes
  logic [DW-1:0] wr_data [0:(1<<AW)-1];
  bit            wr_valid [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 13'h0123) return 8'h5A;
    if (a == 13'h0010) return 8'hA5;
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
  endfunction

  function automatic logic [DW-1:0] mem_peek(input logic [AW-1:0] a);
    return wr_valid[a] ? wr_data[a] : pat(a);
  endfunction

  always @(posedge clock) begin
    if (vram_en && vram_we) begin
      wr_valid[vram_addr] <= 1'b1;
      wr_data[vram_addr]  <= vram_wdata;
    end
    if (vram_en && !vram_we) vram_rdata <= mem_peek(vram_addr);
  end

  // Reference phase: cycles elapsed since reset release, taken mod 4
  always @(posedge clock or posedge reset) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, tb_cyc);
    end
  endtask

  // Advance one clock and check every output against the scheduled model
  task automatic run_cycle();
    int c;
    int q;
    bit exp_issue;
    bit exp_en;
    if ((tb_cyc % 4) == 3) begin
      frame_vid   = vid_en;
      frame_vaddr = vid_addr;
    end
    @(posedge clock); #1;
    c = tb_cyc;
    q = c % 4;
    exp_issue = (c == issue_at);
    exp_en    = (q == 0 && frame_vid) || exp_issue;
    chk("pq", 32'(pq), 32'(q == 1 || q == 2));
    chk("pe", 32'(pe), 32'(q == 2 || q == 3));
    chk("vram_en", 32'(vram_en), 32'(exp_en));
    chk("vram_we", 32'(vram_we), 32'(exp_issue && txn_we));
    if (q == 0 && frame_vid) chk("vram_addr_vid", 32'(vram_addr), 32'(frame_vaddr));
    if (exp_issue) begin
      chk("vram_addr_cpu", 32'(vram_addr), 32'(txn_addr));
      if (txn_we) chk("vram_wdata", 32'(vram_wdata), 32'(txn_wdata));
    end
    chk("vid_valid", 32'(vid_valid), 32'(q == 2 && frame_vid));
    if (q == 2 && frame_vid) chk("vid_data", 32'(vid_data), 32'(mem_peek(frame_vaddr)));
    chk("cpu_ack", 32'(cpu_ack), 32'(c == ack_at));
    chk("cpu_wait", 32'(cpu_wait),
        32'(WAIT_EN && accept_at >= 0 && c > accept_at && c < ack_at));
    if (c == ack_at && !txn_we) chk("cpu_rdata", 32'(cpu_rdata), 32'(txn_rdata));
    if (rand_vid) begin
      vid_en   = ($urandom_range(0, 3) != 0);
      vid_addr = 13'($urandom_range(0, 'hFFF));
    end
    if (accept_at >= 0 && c > accept_at && c <= ack_at) begin
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 13'($urandom);
      cpu_wdata = 8'($urandom);
    end
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < 4 && (tb_cyc % 4) != p; k++) run_cycle();
  endtask

  // Raise a request in the current cycle; the slot it gets follows from its phase:
  // it issues in the first ph2 whose preceding ph1 already saw it pending.
  task automatic cpu_start(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c;
    int lat;
    c   = tb_cyc;
    lat = 4 + ((4 - (c % 4)) % 4);
    txn_we    = we;
    txn_addr  = a;
    txn_wdata = d;
    txn_rdata = mem_peek(a);
    accept_at = c;
    issue_at  = c + lat - 2;
    ack_at    = c + lat;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic do_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold);
    cpu_start(we, a, d);
    repeat (ack_at - accept_at + hold) run_cycle();
    cpu_req = 1'b0;
    run_cycle();
    if (we) chk("mem_write", 32'(mem_peek(a)), 32'(d));
  endtask

  initial begin
    logic [DW-1:0] old_val;

    // T1: reset state, then strobe pattern after release
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pq", 32'(pq), 0);
    chk("rst_pe", 32'(pe), 0);
    chk("rst_vram_en", 32'(vram_en), 0);
    chk("rst_vram_we", 32'(vram_we), 0);
    chk("rst_vram_addr", 32'(vram_addr), 0);
    chk("rst_vram_wdata", 32'(vram_wdata), 0);
    chk("rst_vid_data", 32'(vid_data), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_wait", 32'(cpu_wait), 0);
    reset = 1'b0;
    repeat (8) run_cycle();

    // T2: fixed video fetch
    vid_en   = 1'b1;
    vid_addr = 13'h0123;
    repeat (12) run_cycle();
    chk("t2_vid_data", 32'(vid_data), 32'h5A);

    // T3: best-case CPU write
    wait_phase(0);
    do_txn(1'b1, 13'h1C00, 8'h20, 0);
    chk("t3_mem", 32'(mem_peek(13'h1C00)), 32'h20);

    // T4: late CPU read misses the slot
    wait_phase(1);
    do_txn(1'b0, 13'h0010, 8'h00, 0);
    chk("t4_rdata", 32'(cpu_rdata), 32'hA5);

    // T5: request held past ack, then a fresh accept after one low edge
    wait_phase(0);
    do_txn(1'b0, 13'h1ABC, 8'h00, 3);
    do_txn(1'b1, 13'h1ABD, 8'h77, 0);

    // Randomized traffic: random start phase, gaps, holds and video activity
    rand_vid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(0, 4)) run_cycle();
      do_txn(1'($urandom_range(0, 1)), 13'(13'h1000 + $urandom_range(0, 'hFFF)),
             8'($urandom), $urandom_range(0, 3));
    end

    // T6: reset in the ph2 cycle of a write
    rand_vid = 1'b0;
    vid_en   = 1'b1;
    vid_addr = 13'h0040;
    wait_phase(0);
    old_val = mem_peek(13'h1E00);
    cpu_start(1'b1, 13'h1E00, 8'(old_val ^ 8'hFF));
    run_cycle();
    run_cycle();
    chk("t6_we_before", 32'(vram_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_we_async", 32'(vram_we), 0);
    chk("t6_en_async", 32'(vram_en), 0);
    chk("t6_pe_async", 32'(pe), 0);
    chk("t6_wait_async", 32'(cpu_wait), 0);
    cpu_req   = 1'b0;
    accept_at = -1;
    issue_at  = -1;
    ack_at    = -1;
    frame_vid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (12) run_cycle();
    chk("t6_mem_kept", 32'(mem_peek(13'h1E00)), 32'(old_val));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
